// File: rtl/synth_env_pkg.sv
// Shared constants for the ADSR envelope: state encoding, level limits and
// the sustain-level to Q15.16 target conversion.
package synth_env_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [31:0] PEAK_LVL      = 32'h7FFF_0000;
  localparam logic [15:0] MAX_SIGNED_16 = 16'h7FFF;

  // Bit 15 of the sustain input is masked off so the target never exceeds peak.
  function automatic logic [31:0] sustain_target(input logic [15:0] sl);
    return {sl & MAX_SIGNED_16, 16'h0000};
  endfunction

endpackage

// File: rtl/env_rate_step.sv
// One envelope step: level +/- rate in 33 bits, clamped to a limit.
// reached is set when the limit is hit, crossed, underflowed or rate is zero.
module env_rate_step (
  input  logic [31:0] level,
  input  logic [31:0] rate,
  input  logic [31:0] limit,
  input  logic        dir_up,
  output logic [31:0] next_level,
  output logic        reached
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum        = {1'b0, level} + {1'b0, rate};
    diff       = {1'b0, level} - {1'b0, rate};
    reached    = 1'b0;
    next_level = limit;
    if (dir_up) begin
      reached    = (rate == 32'd0) || (sum >= {1'b0, limit});
      next_level = reached ? limit : sum[31:0];
    end else begin
      // diff[32] is the borrow out, i.e. the subtraction went below zero.
      reached    = (rate == 32'd0) || diff[32] || (diff[31:0] <= limit);
      next_level = reached ? limit : diff[31:0];
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gate edge detection, phase FSM and level register,
// advancing one step per Env_ce tick.
module adsr_envelope
  import synth_env_pkg::*;
#(
  parameter logic [31:0] PEAK_LVL = synth_env_pkg::PEAK_LVL,
  parameter int          FRAC_W   = 16
) (
  input  logic        Sys_clk,
  input  logic        Env_rst,
  input  logic        Env_ce,
  input  logic        Gate,
  input  logic [31:0] Attack_rate,
  input  logic [31:0] Decay_rate,
  input  logic [15:0] Sustain_level,
  input  logic [31:0] Release_rate,
  output logic [31:0] Amplitude,
  output logic [2:0]  Env_state,
  output logic        Env_active
);

  logic [31:0] level_reg, level_next;
  logic [2:0]  state_reg, state_next;
  logic        gate_d_reg;

  logic        rise, fall;
  logic [2:0]  eff_state;
  logic [31:0] sustain_lvl;
  logic        step_up;
  logic [31:0] step_rate, step_limit, step_level;
  logic        step_reached;

  env_rate_step u_step (
    .level      (level_reg),
    .rate       (step_rate),
    .limit      (step_limit),
    .dir_up     (step_up),
    .next_level (step_level),
    .reached    (step_reached)
  );

  // Edge-triggered transitions take effect on the same tick, so the new
  // phase's first step is applied immediately.
  always_comb begin
    rise        = Gate & ~gate_d_reg;
    fall        = ~Gate & gate_d_reg;
    sustain_lvl = sustain_target(Sustain_level);

    eff_state = state_reg;
    if (rise) begin
      eff_state = ST_ATTACK;
    end else if (fall && (state_reg == ST_ATTACK || state_reg == ST_DECAY ||
                          state_reg == ST_SUSTAIN)) begin
      eff_state = ST_RELEASE;
    end

    step_up    = 1'b0;
    step_rate  = 32'd0;
    step_limit = 32'd0;
    case (eff_state)
      ST_ATTACK: begin
        step_up    = 1'b1;
        step_rate  = Attack_rate;
        step_limit = PEAK_LVL;
      end
      ST_DECAY: begin
        step_rate  = Decay_rate;
        step_limit = sustain_lvl;
      end
      ST_RELEASE: begin
        step_rate  = Release_rate;
        step_limit = 32'd0;
      end
      default: ;
    endcase

    level_next = 32'd0;
    state_next = eff_state;
    case (eff_state)
      ST_ATTACK: begin
        level_next = step_level;
        if (step_reached) state_next = ST_DECAY;
      end
      ST_DECAY: begin
        level_next = step_level;
        if (step_reached) state_next = ST_SUSTAIN;
      end
      ST_SUSTAIN: level_next = sustain_lvl;
      ST_RELEASE: begin
        level_next = step_level;
        if (step_reached) state_next = ST_IDLE;
      end
      default: begin
        level_next = 32'd0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (Env_rst) begin
      level_reg  <= 32'd0;
      state_reg  <= ST_IDLE;
      gate_d_reg <= 1'b0;
    end else if (Env_ce) begin
      level_reg  <= level_next;
      state_reg  <= state_next;
      gate_d_reg <= Gate;
    end
  end

  assign Amplitude  = {17'b0, level_reg[FRAC_W+14:FRAC_W]};
  assign Env_state  = state_reg;
  assign Env_active = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope: reset, full ADSR cycle,
// legato retrigger, sustain tracking, zero rates, sparse ce, reset mid-envelope.
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        gate;
  logic [31:0] attack_rate;
  logic [31:0] decay_rate;
  logic [15:0] sustain_level;
  logic [31:0] release_rate;
  logic [31:0] amplitude;
  logic [2:0]  env_state;
  logic        env_active;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adsr_envelope dut (
    .Sys_clk       (clk),
    .Env_rst       (rst),
    .Env_ce        (ce),
    .Gate          (gate),
    .Attack_rate   (attack_rate),
    .Decay_rate    (decay_rate),
    .Sustain_level (sustain_level),
    .Release_rate  (release_rate),
    .Amplitude     (amplitude),
    .Env_state     (env_state),
    .Env_active    (env_active)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; gate = 1'b1;
    tick();
    checks++;
    if (amplitude !== 32'd0) begin
      failures++; $display("FAIL reset_amp amplitude=%h expected=%h", amplitude, 32'd0);
    end
    checks++;
    if (env_state !== 3'd0) begin
      failures++; $display("FAIL reset_state state=%0d expected=0", env_state);
    end
    checks++;
    if (env_active !== 1'b0) begin
      failures++; $display("FAIL reset_active active=%b expected=0", env_active);
    end
    gate = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (env_state !== 3'd0) begin
      failures++; $display("FAIL reset_idle state=%0d expected=0", env_state);
    end
    $display("test_reset done amplitude=%h state=%0d", amplitude, env_state);
  endtask

  task automatic test_full_adsr();
    logic [31:0] exp;
    attack_rate = 32'h0800_0000; decay_rate = 32'h0100_0000;
    sustain_level = 16'h4000; release_rate = 32'h0200_0000;
    ce = 1'b1;
    gate = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i < 16) ? 32'(i * 32'h800) : 32'h7FFF;
      checks++;
      if (amplitude !== exp) begin
        failures++; $display("FAIL attack_t%0d amplitude=%h expected=%h", i, amplitude, exp);
      end
      if (i == 1) begin
        checks++;
        if (env_state !== 3'd1) begin
          failures++; $display("FAIL attack_state state=%0d expected=1", env_state);
        end
      end
    end
    checks++;
    if (env_state !== 3'd2) begin
      failures++; $display("FAIL attack_to_decay state=%0d expected=2", env_state);
    end
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp = (k < 64) ? 32'(32'h7FFF - k * 32'h100) : 32'h4000;
      checks++;
      if (amplitude !== exp) begin
        failures++; $display("FAIL decay_t%0d amplitude=%h expected=%h", k, amplitude, exp);
      end
      if (k == 63) begin
        checks++;
        if (env_state !== 3'd2) begin
          failures++; $display("FAIL decay_hold state=%0d expected=2", env_state);
        end
      end
    end
    checks++;
    if (env_state !== 3'd3) begin
      failures++; $display("FAIL decay_to_sustain state=%0d expected=3", env_state);
    end
    tick();
    checks++;
    if (amplitude !== 32'h4000) begin
      failures++; $display("FAIL sustain_hold amplitude=%h expected=4000", amplitude);
    end
    gate = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp = 32'(32'h4000 - k * 32'h200);
      checks++;
      if (amplitude !== exp) begin
        failures++; $display("FAIL release_t%0d amplitude=%h expected=%h", k, amplitude, exp);
      end
      if (k == 31) begin
        checks++;
        if (env_state !== 3'd4) begin
          failures++; $display("FAIL release_state state=%0d expected=4", env_state);
        end
      end
    end
    checks++;
    if (env_state !== 3'd0 || env_active !== 1'b0) begin
      failures++; $display("FAIL release_to_idle state=%0d active=%b expected=0/0", env_state, env_active);
    end
    $display("test_full_adsr done amplitude=%h state=%0d", amplitude, env_state);
  endtask

  task automatic test_retrigger();
    logic [31:0] exp;
    gate = 1'b1;
    for (int i = 0; i < 80; i++) tick();
    checks++;
    if (env_state !== 3'd3 || amplitude !== 32'h4000) begin
      failures++; $display("FAIL retrig_setup state=%0d amplitude=%h expected=3/4000", env_state, amplitude);
    end
    gate = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (env_state !== 3'd4 || amplitude !== 32'h2000) begin
      failures++; $display("FAIL retrig_release state=%0d amplitude=%h expected=4/2000", env_state, amplitude);
    end
    gate = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = (i < 12) ? 32'(32'h2000 + i * 32'h800) : 32'h7FFF;
      checks++;
      if (amplitude !== exp) begin
        failures++; $display("FAIL retrig_t%0d amplitude=%h expected=%h", i, amplitude, exp);
      end
    end
    checks++;
    if (env_state !== 3'd2) begin
      failures++; $display("FAIL retrig_to_decay state=%0d expected=2", env_state);
    end
    $display("test_retrigger done amplitude=%h state=%0d", amplitude, env_state);
  endtask

  task automatic test_sustain_tracking();
    for (int i = 0; i < 64; i++) tick();
    checks++;
    if (env_state !== 3'd3 || amplitude !== 32'h4000) begin
      failures++; $display("FAIL track_setup state=%0d amplitude=%h expected=3/4000", env_state, amplitude);
    end
    sustain_level = 16'h1000;
    tick();
    checks++;
    if (amplitude !== 32'h1000) begin
      failures++; $display("FAIL track_1000 amplitude=%h expected=1000", amplitude);
    end
    sustain_level = 16'hFFFF;
    tick();
    checks++;
    if (amplitude !== 32'h7FFF) begin
      failures++; $display("FAIL track_ffff amplitude=%h expected=7fff", amplitude);
    end
    sustain_level = 16'h4000;
    tick();
    checks++;
    if (amplitude !== 32'h4000 || env_state !== 3'd3) begin
      failures++; $display("FAIL track_4000 amplitude=%h state=%0d expected=4000/3", amplitude, env_state);
    end
    $display("test_sustain_tracking done amplitude=%h", amplitude);
  endtask

  task automatic test_zero_rates();
    attack_rate = 32'd0; decay_rate = 32'd0; release_rate = 32'd0;
    gate = 1'b0;
    tick();
    checks++;
    if (amplitude !== 32'd0 || env_state !== 3'd0) begin
      failures++; $display("FAIL zero_release amplitude=%h state=%0d expected=0/0", amplitude, env_state);
    end
    gate = 1'b1;
    tick();
    checks++;
    if (amplitude !== 32'h7FFF || env_state !== 3'd2) begin
      failures++; $display("FAIL zero_attack amplitude=%h state=%0d expected=7fff/2", amplitude, env_state);
    end
    tick();
    checks++;
    if (amplitude !== 32'h4000 || env_state !== 3'd3) begin
      failures++; $display("FAIL zero_decay amplitude=%h state=%0d expected=4000/3", amplitude, env_state);
    end
    gate = 1'b0;
    tick();
    checks++;
    if (amplitude !== 32'd0 || env_state !== 3'd0) begin
      failures++; $display("FAIL zero_fall amplitude=%h state=%0d expected=0/0", amplitude, env_state);
    end
    sustain_level = 16'h0000;
    gate = 1'b1;
    tick();
    tick();
    checks++;
    if (amplitude !== 32'd0 || env_state !== 3'd3 || env_active !== 1'b1) begin
      failures++; $display("FAIL zero_sustain amplitude=%h state=%0d active=%b expected=0/3/1", amplitude, env_state, env_active);
    end
    gate = 1'b0;
    tick();
    sustain_level = 16'h4000;
    $display("test_zero_rates done amplitude=%h state=%0d", amplitude, env_state);
  endtask

  task automatic test_sparse_ce();
    attack_rate = 32'h0800_0000; decay_rate = 32'h0100_0000; release_rate = 32'h0200_0000;
    ce = 1'b0; gate = 1'b0;
    tick();
    tick();
    gate = 1'b1;
    tick();
    checks++;
    if (env_state !== 3'd0) begin
      failures++; $display("FAIL sparse_noce_state state=%0d expected=0", env_state);
    end
    tick();
    gate = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    checks++;
    if (amplitude !== 32'd0 || env_state !== 3'd0) begin
      failures++; $display("FAIL sparse_pulse amplitude=%h state=%0d expected=0/0", amplitude, env_state);
    end
    gate = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    checks++;
    if (amplitude !== 32'h800 || env_state !== 3'd1) begin
      failures++; $display("FAIL sparse_tick1 amplitude=%h state=%0d expected=800/1", amplitude, env_state);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (amplitude !== 32'h800) begin
      failures++; $display("FAIL sparse_hold amplitude=%h expected=800", amplitude);
    end
    ce = 1'b1;
    tick();
    ce = 1'b0;
    checks++;
    if (amplitude !== 32'h1000) begin
      failures++; $display("FAIL sparse_tick2 amplitude=%h expected=1000", amplitude);
    end
    gate = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    gate = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    checks++;
    if (amplitude !== 32'h1800 || env_state !== 3'd1) begin
      failures++; $display("FAIL sparse_glitch amplitude=%h state=%0d expected=1800/1", amplitude, env_state);
    end
    $display("test_sparse_ce done amplitude=%h state=%0d", amplitude, env_state);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; ce = 1'b0;
    tick();
    checks++;
    if (amplitude !== 32'd0 || env_state !== 3'd0 || env_active !== 1'b0) begin
      failures++; $display("FAIL reset_mid amplitude=%h state=%0d active=%b expected=0/0/0", amplitude, env_state, env_active);
    end
    rst = 1'b0; gate = 1'b0; ce = 1'b1;
    tick();
    checks++;
    if (amplitude !== 32'd0 || env_state !== 3'd0) begin
      failures++; $display("FAIL reset_mid_after amplitude=%h state=%0d expected=0/0", amplitude, env_state);
    end
    $display("test_reset_mid done amplitude=%h state=%0d", amplitude, env_state);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; gate = 1'b0;
    attack_rate = 32'd0; decay_rate = 32'd0;
    sustain_level = 16'h4000; release_rate = 32'd0;
    tick();
    test_reset();
    test_full_adsr();
    test_retrigger();
    test_sustain_tracking();
    test_zero_rates();
    test_sparse_ce();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
